// File: rtl/eip_step_ctrl_pkg.sv
// Shared constants for the Tiny86 EIP step controller:
// FSM encodings, halt reasons, command codes, EFLAGS bits.
package eip_step_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [2:0] HR_NONE  = 3'd0;
  localparam logic [2:0] HR_HLT   = 3'd1;
  localparam logic [2:0] HR_LIMIT = 3'd2;
  localparam logic [2:0] HR_LOOP  = 3'd3;
  localparam logic [2:0] HR_FETCH = 3'd4;
  localparam logic [2:0] HR_LEN   = 3'd5;

  localparam logic [6:0] CMD_NOP  = 7'h00;
  localparam logic [6:0] CMD_HLT  = 7'h01;
  localparam logic [6:0] CMD_JMP  = 7'h02;
  localparam logic [6:0] CMD_JMPI = 7'h03;
  localparam logic [6:0] CMD_JE   = 7'h04;
  localparam logic [6:0] CMD_JNE  = 7'h05;
  localparam logic [6:0] CMD_LOOP = 7'h06;

  localparam int ZF_BIT = 6;

endpackage

// File: rtl/eip_step_ctrl_cfu.sv
// Control flow unit: next EIP from current EIP,
// opcode, length, flags and branch operand.
module eip_step_ctrl_cfu
  import eip_step_ctrl_pkg::*;
(
  input  logic [31:0] eip_i,
  input  logic [6:0]  opc_i,
  input  logic [3:0]  len_i,
  input  logic [31:0] eflags_i,
  input  logic        ecx_zero_i,
  input  logic [31:0] address_i,
  output logic [31:0] next_eip_o
);

  logic [31:0] seq;
  logic [31:0] rel;
  logic        zf;

  assign seq = eip_i + {28'd0, len_i};
  assign rel = seq + address_i;
  assign zf  = eflags_i[ZF_BIT];

  always_comb begin
    next_eip_o = seq;
    unique case (1'b1)
      (opc_i == CMD_JMP):  next_eip_o = rel;
      (opc_i == CMD_JMPI): next_eip_o = address_i;
      (opc_i == CMD_JE):   next_eip_o = zf ? rel : seq;
      (opc_i == CMD_JNE):  next_eip_o = zf ? seq : rel;
      (opc_i == CMD_LOOP): next_eip_o = ecx_zero_i ? seq : rel;
      default:             next_eip_o = seq;
    endcase
  end

endmodule

// File: rtl/eip_step_ctrl.sv
// Per-instruction sequencer: owns EIP, steps FETCH/EXEC/COMMIT,
// and stops on HLT, step limit, self-loop or fetch fault.
module eip_step_ctrl
  import eip_step_ctrl_pkg::*;
#(
  parameter int         STEP_W   = 32,
  parameter logic [6:0] HALT_OPC = CMD_HLT,
  parameter int         MAX_LEN  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       entry_eip,
  input  logic [STEP_W-1:0] step_limit,
  output logic              fetch_req_valid,
  input  logic              fetch_req_ready,
  output logic [31:0]       fetch_req_eip,
  input  logic              fetch_rsp_valid,
  input  logic [6:0]        fetch_rsp_opc,
  input  logic [3:0]        fetch_rsp_len,
  input  logic              fetch_rsp_fault,
  output logic              exec_req_valid,
  input  logic              exec_rsp_valid,
  input  logic [31:0]       exec_eflags,
  input  logic              exec_ecx_zero,
  input  logic [31:0]       exec_address,
  output logic              commit_valid,
  output logic [31:0]       commit_eip,
  output logic [31:0]       commit_next_eip,
  output logic [31:0]       eip,
  output logic [STEP_W-1:0] step_count,
  output logic              busy,
  output logic              halted,
  output logic              faulted,
  output logic [2:0]        halt_reason
);

  logic [2:0]        state_q, state_d;
  logic [31:0]       eip_q, eip_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] limit_q, limit_d;
  logic [2:0]        reason_q, reason_d;
  logic [6:0]        opc_q, opc_d;
  logic [3:0]        len_q, len_d;
  logic [31:0]       eflags_q, eflags_d;
  logic              ecxz_q, ecxz_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       next_eip;
  logic [STEP_W-1:0] step_inc;
  logic              len_bad;

  // Fed only from latches so next_eip is stable through COMMIT.
  eip_step_ctrl_cfu u_cfu (
    .eip_i      (eip_q),
    .opc_i      (opc_q),
    .len_i      (len_q),
    .eflags_i   (eflags_q),
    .ecx_zero_i (ecxz_q),
    .address_i  (addr_q),
    .next_eip_o (next_eip)
  );

  assign step_inc = step_q + STEP_W'(1);
  assign len_bad  = (fetch_rsp_len == 4'd0) ||
                    ({1'b0, fetch_rsp_len} > 5'(MAX_LEN));

  always_comb begin
    state_d  = state_q;
    eip_d    = eip_q;
    step_d   = step_q;
    limit_d  = limit_q;
    reason_d = reason_q;
    opc_d    = opc_q;
    len_d    = len_q;
    eflags_d = eflags_q;
    ecxz_d   = ecxz_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_d  = S_FETCH;
          eip_d    = entry_eip;
          step_d   = '0;
          limit_d  = step_limit;
          reason_d = HR_NONE;
        end
      end
      S_FETCH: begin
        if (fetch_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fetch_rsp_valid) begin
          if (fetch_rsp_fault) begin
            state_d  = S_FAULT;
            reason_d = HR_FETCH;
          end else if (len_bad) begin
            state_d  = S_FAULT;
            reason_d = HR_LEN;
          end else begin
            state_d = S_EXEC;
            opc_d   = fetch_rsp_opc;
            len_d   = fetch_rsp_len;
          end
        end
      end
      S_EXEC: begin
        if (exec_rsp_valid) begin
          state_d  = S_COMMIT;
          eflags_d = exec_eflags;
          ecxz_d   = exec_ecx_zero;
          addr_d   = exec_address;
        end
      end
      S_COMMIT: begin
        eip_d  = next_eip;
        step_d = step_inc;
        if (opc_q == HALT_OPC) begin
          state_d  = S_HALT;
          reason_d = HR_HLT;
        end else if (limit_q != '0 && step_inc == limit_q) begin
          state_d  = S_HALT;
          reason_d = HR_LIMIT;
        end else if (next_eip == eip_q) begin
          state_d  = S_HALT;
          reason_d = HR_LOOP;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      eip_q    <= '0;
      step_q   <= '0;
      limit_q  <= '0;
      reason_q <= HR_NONE;
      opc_q    <= '0;
      len_q    <= '0;
      eflags_q <= '0;
      ecxz_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      eip_q    <= eip_d;
      step_q   <= step_d;
      limit_q  <= limit_d;
      reason_q <= reason_d;
      opc_q    <= opc_d;
      len_q    <= len_d;
      eflags_q <= eflags_d;
      ecxz_q   <= ecxz_d;
      addr_q   <= addr_d;
    end
  end

  assign fetch_req_valid = (state_q == S_FETCH);
  assign fetch_req_eip   = eip_q;
  assign exec_req_valid  = (state_q == S_EXEC);
  assign commit_valid    = (state_q == S_COMMIT);
  assign commit_eip      = eip_q;
  assign commit_next_eip = next_eip;
  assign eip             = eip_q;
  assign step_count      = step_q;
  assign halted          = (state_q == S_HALT);
  assign faulted         = (state_q == S_FAULT);
  assign busy            = !(state_q == S_IDLE || halted || faulted);
  assign halt_reason     = reason_q;

endmodule

// File: tb/tb_eip_step_ctrl.sv
// Directed bench for eip_step_ctrl: drives fetch/exec
// handshakes by hand and checks commits and halt status.
module tb_eip_step_ctrl;

  localparam logic [6:0] NOP  = 7'h00;
  localparam logic [6:0] HLT  = 7'h01;
  localparam logic [6:0] JMPI = 7'h03;
  localparam logic [6:0] JE   = 7'h04;
  localparam logic [31:0] ZF  = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] entry_eip;
  logic [31:0] step_limit;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [31:0] fetch_req_eip;
  logic        fetch_rsp_valid;
  logic [6:0]  fetch_rsp_opc;
  logic [3:0]  fetch_rsp_len;
  logic        fetch_rsp_fault;
  logic        exec_req_valid;
  logic        exec_rsp_valid;
  logic [31:0] exec_eflags;
  logic        exec_ecx_zero;
  logic [31:0] exec_address;
  logic        commit_valid;
  logic [31:0] commit_eip;
  logic [31:0] commit_next_eip;
  logic [31:0] eip;
  logic [31:0] step_count;
  logic        busy;
  logic        halted;
  logic        faulted;
  logic [2:0]  halt_reason;

  int errors = 0;
  int checks = 0;
  int ncommit = 0;
  int base;

  always #5 clk = ~clk;

  always @(negedge clk) if (commit_valid) ncommit++;

  eip_step_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .entry_eip       (entry_eip),
    .step_limit      (step_limit),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_req_eip   (fetch_req_eip),
    .fetch_rsp_valid (fetch_rsp_valid),
    .fetch_rsp_opc   (fetch_rsp_opc),
    .fetch_rsp_len   (fetch_rsp_len),
    .fetch_rsp_fault (fetch_rsp_fault),
    .exec_req_valid  (exec_req_valid),
    .exec_rsp_valid  (exec_rsp_valid),
    .exec_eflags     (exec_eflags),
    .exec_ecx_zero   (exec_ecx_zero),
    .exec_address    (exec_address),
    .commit_valid    (commit_valid),
    .commit_eip      (commit_eip),
    .commit_next_eip (commit_next_eip),
    .eip             (eip),
    .step_count      (step_count),
    .busy            (busy),
    .halted          (halted),
    .faulted         (faulted),
    .halt_reason     (halt_reason)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] entry, input logic [31:0] lim);
    start = 1'b1;
    entry_eip = entry;
    step_limit = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] at, input logic [6:0] opc,
                       input logic [3:0] len, input logic flt);
    int n = 0;
    while (!fetch_req_valid && n < 8) begin
      tick();
      n++;
    end
    chk("fetch_req_valid", {31'd0, fetch_req_valid}, 32'd1);
    chk("fetch_req_eip", fetch_req_eip, at);
    fetch_req_ready = 1'b1;
    tick();
    fetch_req_ready = 1'b0;
    fetch_rsp_valid = 1'b1;
    fetch_rsp_opc = opc;
    fetch_rsp_len = len;
    fetch_rsp_fault = flt;
    tick();
    fetch_rsp_valid = 1'b0;
    fetch_rsp_fault = 1'b0;
  endtask

  task automatic exec_commit(input logic [31:0] fl, input logic [31:0] ad,
                             input logic [31:0] at, input logic [31:0] nx);
    chk("exec_req_valid", {31'd0, exec_req_valid}, 32'd1);
    exec_rsp_valid = 1'b1;
    exec_eflags = fl;
    exec_address = ad;
    tick();
    exec_rsp_valid = 1'b0;
    chk("commit_valid", {31'd0, commit_valid}, 32'd1);
    chk("commit_eip", commit_eip, at);
    chk("commit_next_eip", commit_next_eip, nx);
    tick();
    chk("eip_after", eip, nx);
  endtask

  task automatic issue(input logic [31:0] at, input logic [6:0] opc,
                       input logic [3:0] len, input logic [31:0] fl,
                       input logic [31:0] ad, input logic [31:0] nx);
    fetch(at, opc, len, 1'b0);
    exec_commit(fl, ad, at, nx);
  endtask

  task automatic stop_chk(input string tag, input logic h, input logic f,
                          input logic [2:0] r);
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
    chk({tag, "_faulted"}, {31'd0, faulted}, {31'd0, f});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_reason"}, {29'd0, halt_reason}, {29'd0, r});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    entry_eip = '0;
    step_limit = '0;
    fetch_req_ready = 1'b0;
    fetch_rsp_valid = 1'b0;
    fetch_rsp_opc = '0;
    fetch_rsp_len = '0;
    fetch_rsp_fault = 1'b0;
    exec_rsp_valid = 1'b0;
    exec_eflags = '0;
    exec_ecx_zero = 1'b0;
    exec_address = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_eip", eip, 32'd0);
    chk("rst_steps", step_count, 32'd0);
    chk("rst_reason", {29'd0, halt_reason}, 32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_req_valid}, 32'd0);
    chk("rst_commit", {31'd0, commit_valid}, 32'd0);

    // NOP then HLT
    go(32'h1000, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    issue(32'h1000, NOP, 4'd2, 32'd0, 32'd0, 32'h1002);
    issue(32'h1002, HLT, 4'd1, 32'd0, 32'd0, 32'h1003);
    stop_chk("hlt", 1'b1, 1'b0, 3'd1);
    chk("hlt_steps", step_count, 32'd2);

    // JE taken, JE not taken, JMPi self-loop
    go(32'h2000, 32'd0);
    issue(32'h2000, JE, 4'd2, ZF, 32'h10, 32'h2012);
    issue(32'h2012, JE, 4'd2, 32'd0, 32'h10, 32'h2014);
    issue(32'h2014, JMPI, 4'd1, 32'd0, 32'h2014, 32'h2014);
    stop_chk("loop", 1'b1, 1'b0, 3'd3);
    chk("loop_steps", step_count, 32'd3);

    // Step limit, then restart clears count
    base = ncommit;
    go(32'h3000, 32'd3);
    issue(32'h3000, NOP, 4'd1, 32'd0, 32'd0, 32'h3001);
    issue(32'h3001, NOP, 4'd1, 32'd0, 32'd0, 32'h3002);
    issue(32'h3002, NOP, 4'd1, 32'd0, 32'd0, 32'h3003);
    stop_chk("limit", 1'b1, 1'b0, 3'd2);
    chk("limit_steps", step_count, 32'd3);
    tick();
    tick();
    chk("limit_commits", ncommit - base, 32'd3);
    chk("limit_idle_fetch", {31'd0, fetch_req_valid}, 32'd0);
    go(32'h4000, 32'd3);
    chk("restart_steps", step_count, 32'd0);
    chk("restart_reason", {29'd0, halt_reason}, 32'd0);
    issue(32'h4000, NOP, 4'd1, 32'd0, 32'd0, 32'h4001);
    chk("restart_steps1", step_count, 32'd1);
    issue(32'h4001, HLT, 4'd1, 32'd0, 32'd0, 32'h4002);
    stop_chk("restart_hlt", 1'b1, 1'b0, 3'd1);

    // Bad length and fetch fault
    base = ncommit;
    go(32'h5000, 32'd0);
    fetch(32'h5000, NOP, 4'd0, 1'b0);
    stop_chk("badlen", 1'b0, 1'b1, 3'd5);
    go(32'h5000, 32'd0);
    fetch(32'h5000, NOP, 4'd2, 1'b1);
    stop_chk("ffault", 1'b0, 1'b1, 3'd4);
    tick();
    chk("fault_commits", ncommit - base, 32'd0);

    // Reset during EXEC with response present
    base = ncommit;
    go(32'h6000, 32'd0);
    fetch(32'h6000, NOP, 4'd2, 1'b0);
    chk("mid_exec_valid", {31'd0, exec_req_valid}, 32'd1);
    exec_rsp_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_eip", eip, 32'd0);
    chk("mid_rst_commit", {31'd0, commit_valid}, 32'd0);
    chk("mid_rst_exec", {31'd0, exec_req_valid}, 32'd0);
    rst_n = 1'b1;
    exec_rsp_valid = 1'b0;
    tick();
    chk("mid_rst_commits", ncommit - base, 32'd0);
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);

    // EIP wraps; start while busy is ignored
    go(32'hFFFF_FFFE, 32'd0);
    issue(32'hFFFF_FFFE, NOP, 4'd3, 32'd0, 32'd0, 32'h0000_0001);
    go(32'h0000_9999, 32'd0);
    chk("busy_start_eip", fetch_req_eip, 32'h0000_0001);
    issue(32'h0000_0001, HLT, 4'd1, 32'd0, 32'd0, 32'h0000_0002);
    stop_chk("wrap", 1'b1, 1'b0, 3'd1);
    chk("wrap_steps", step_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
